pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the PC value loaded at reset.
REQ-002 Parameter INSTR_W, default 16, SHALL be the instruction word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-005 pc_overwrite  input  1  SHALL be the branch/jump redirect strobe from the PC datapath.
REQ-006 overwrite_data  input  8  SHALL be the redirect target, valid when pc_overwrite=1.
REQ-007 stall  input  1  SHALL be the downstream hold; instr is not consumed while 1.
REQ-008 halt  input  1  SHALL be the decoded HALT request.
REQ-009 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-010 imem_addr  output  8  SHALL be the read address, equal to pc_q.
REQ-011 imem_ack  input  1  SHALL be the memory acknowledge; imem_rdata valid in the same cycle.
REQ-012 imem_rdata  input  INSTR_W  SHALL be the fetched instruction word.
REQ-013 instr_valid  output  1  SHALL flag a valid fetched instruction on instr/instr_pc.
REQ-014 instr  output  INSTR_W  SHALL be the held instruction.
REQ-015 instr_pc  output  8  SHALL be the address of instr (feeds the datapath pc_mux input).
REQ-016 halted  output  1  SHALL be 1 while the FSM is in HALTED.

Function
REQ-017 FSM states SHALL be WAKE, RUN, HALTED; WAKE->RUN unconditionally after one cycle, RUN->HALTED on halt=1, HALTED exited only by reset.
REQ-018 imem_req SHALL be 1 only in RUN, and only when !(instr_valid && stall) and pc_overwrite=0.
REQ-019 A fetch SHALL complete in the cycle imem_req && imem_ack; next edge: instr<=imem_rdata, instr_pc<=pc_q, instr_valid<=1, pc_q<=pc_q+1.
REQ-020 PC increment SHALL be unsigned 8-bit and wrap 8'hFF -> 8'h00.
REQ-021 instr SHALL be consumed on any edge with instr_valid=1 and stall=0; with no concurrent fetch, instr_valid<=0.
REQ-022 Consume and fetch in the same cycle SHALL load the new word with instr_valid staying 1 (zero-bubble throughput, one instruction per cycle with a 0-wait memory).
REQ-023 While instr_valid && stall, instr, instr_pc, pc_q SHALL hold unchanged.
REQ-024 pc_overwrite=1 SHALL load pc_q<=overwrite_data, clear instr_valid, and discard any imem_ack/imem_rdata in that cycle, regardless of stall.
REQ-025 Memory SHALL tolerate imem_req deassertion or imem_addr change before imem_ack; no request is sticky.
REQ-026 halt=1 SHALL clear instr_valid and block further fetches; if pc_overwrite is also 1, pc_q still takes overwrite_data.
REQ-027 In HALTED, pc_overwrite SHALL still update pc_q but SHALL NOT restart fetching.

Reset
REQ-028 On rst_n=0, asynchronously: state=WAKE, pc_q=RESET_PC, instr_valid=0, instr=0, instr_pc=0, imem_req=0, halted=0.
REQ-029 Reset asserted mid-fetch SHALL abandon the fetch; no partial instruction SHALL appear after release.

Structure
REQ-030 FSM state encoding, RESET_PC default and PC width (8) SHALL live in the shared core package.
REQ-031 The block SHALL be one module with no sub-modules; pc_datapath stays external and drives pc_overwrite/overwrite_data.

Verification
REQ-032 Reset release, imem_ack=1 every cycle, stall=0 -> imem_addr 00,01,02 on consecutive cycles; instr_pc follows one cycle later; no bubbles.
REQ-033 pc_q=8'hFF fetch acked -> next imem_addr=8'h00, instr_pc=8'hFF.
REQ-034 stall=1 for 3 cycles with instr_valid=1 at PC 05 -> imem_req=0, instr/instr_pc=05 held; stall=0 -> PC 06 fetched next cycle.
REQ-035 pc_overwrite=1, overwrite_data=8'h40 same cycle as imem_ack -> acked word dropped, instr_valid=0 next cycle, next imem_addr=8'h40.
REQ-036 halt=1 at PC 10 -> halted=1, imem_req=0 permanently; pc_overwrite to 8'h20 changes pc_q only; rst_n pulse -> WAKE, fetch from RESET_PC.
REQ-037 rst_n=0 asserted mid-cycle with imem_req=1 -> outputs reset immediately without waiting for clk.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared core definitions for the instruction fetch unit:
//               PC width, reset vector and fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    localparam int unsigned PC_W = 8;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        ST_WAKE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // Unsigned increment; wraps 8'hFF -> 8'h00 by truncation.
    function automatic logic [PC_W-1:0] pc_next_seq(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch
// Description : Single-stage instruction fetch. Holds the PC, requests words
//               from instruction memory and presents them with a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_overwrite,
    input  logic [PC_W-1:0]    overwrite_data,
    input  logic               stall,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               halted
);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [PC_W-1:0]     instr_pc_q, instr_pc_d;

    logic                req;
    logic                fetch_done;
    logic                consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_WAKE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Requests are purely combinational so a redirect or halt withdraws them
    // in the same cycle; the memory never sees a sticky request.
    always_comb begin
        req = 1'b0;
        if (state_q == ST_RUN && !(instr_valid_q && stall) && !pc_overwrite && !halt) begin
            req = 1'b1;
        end
    end

    assign fetch_done = req && imem_ack;
    assign consume    = instr_valid_q && !stall;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAKE:   state_d = ST_RUN;
            ST_RUN:    if (halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_WAKE;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        if (pc_overwrite) begin
            pc_d = overwrite_data;
        end else if (fetch_done) begin
            pc_d = pc_next_seq(pc_q);
        end

        // fetch_done is never set alongside a redirect or halt, so the
        // priority below only matters for clearing the held word.
        if (pc_overwrite || halt) begin
            instr_valid_d = 1'b0;
        end else if (fetch_done) begin
            instr_valid_d = 1'b1;
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
        end else if (consume) begin
            instr_valid_d = 1'b0;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = (state_q == ST_HALTED);

endmodule : pc_fetch
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch
// Description : Directed self-checking bench for pc_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_overwrite;
    logic [7:0]  overwrite_data;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Zero-wait memory: each word encodes its own address.
    assign imem_rdata = {~imem_addr, imem_addr};

    function automatic logic [15:0] word_at(input logic [7:0] a);
        return {~a, a};
    endfunction

    pc_fetch #(.RESET_PC(8'h00), .INSTR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_overwrite   (pc_overwrite),
        .overwrite_data (overwrite_data),
        .stall          (stall),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h exp 00", imem_addr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h exp 0000", instr); end
        checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL reset_instr_pc: got %h exp 00", instr_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL seq_first: req=%b addr=%h valid=%b exp 1/00/0", imem_req, imem_addr, instr_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++; if (imem_addr !== 8'(i) || instr_pc !== 8'(i-1) || instr_valid !== 1'b1 || instr !== word_at(8'(i-1))) begin
                errors++; $display("FAIL seq_%0d: addr=%h ipc=%h valid=%b instr=%h exp %h/%h/1/%h",
                                   i, imem_addr, instr_pc, instr_valid, instr, 8'(i), 8'(i-1), word_at(8'(i-1)));
            end
        end
    endtask

    task automatic test_wrap();
        pc_overwrite = 1'b1; overwrite_data = 8'hFE;
        @(negedge clk);
        pc_overwrite = 1'b0;
        checks++; if (imem_addr !== 8'hFE || instr_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_redirect: addr=%h valid=%b exp FE/0", imem_addr, instr_valid);
        end
        @(negedge clk);
        checks++; if (imem_addr !== 8'hFF || instr_pc !== 8'hFE) begin
            errors++; $display("FAIL wrap_ff: addr=%h ipc=%h exp FF/FE", imem_addr, instr_pc);
        end
        @(negedge clk);
        checks++; if (imem_addr !== 8'h00 || instr_pc !== 8'hFF || instr !== word_at(8'hFF) || instr_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_00: addr=%h ipc=%h instr=%h valid=%b exp 00/FF/%h/1", imem_addr, instr_pc, instr, instr_valid, word_at(8'hFF));
        end
    endtask

    task automatic test_stall();
        pc_overwrite = 1'b1; overwrite_data = 8'h05;
        @(negedge clk);
        pc_overwrite = 1'b0; stall = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
            errors++; $display("FAIL stall_empty_req: req=%b addr=%h exp 1/05", imem_req, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h05 || instr !== word_at(8'h05) || imem_addr !== 8'h06) begin
                errors++; $display("FAIL stall_hold_%0d: req=%b valid=%b ipc=%h instr=%h addr=%h exp 0/1/05/%h/06",
                                   i, imem_req, instr_valid, instr_pc, instr, imem_addr, word_at(8'h05));
            end
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h06) begin
            errors++; $display("FAIL stall_release_req: req=%b addr=%h exp 1/06", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++; if (instr_pc !== 8'h06 || instr_valid !== 1'b1 || imem_addr !== 8'h07) begin
            errors++; $display("FAIL stall_resume: ipc=%h valid=%b addr=%h exp 06/1/07", instr_pc, instr_valid, imem_addr);
        end
    endtask

    task automatic test_overwrite();
        pc_overwrite = 1'b1; overwrite_data = 8'h40;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ovw_req: got %b exp 0", imem_req); end
        @(negedge clk);
        pc_overwrite = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'h40 || instr_pc !== 8'h06) begin
            errors++; $display("FAIL ovw_drop: valid=%b addr=%h ipc=%h exp 0/40/06", instr_valid, imem_addr, instr_pc);
        end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40 || imem_addr !== 8'h41) begin
            errors++; $display("FAIL ovw_target: valid=%b ipc=%h addr=%h exp 1/40/41", instr_valid, instr_pc, imem_addr);
        end
    endtask

    task automatic test_halt();
        pc_overwrite = 1'b1; overwrite_data = 8'h10;
        @(negedge clk);
        pc_overwrite = 1'b0; halt = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req_now: got %b exp 0", imem_req); end
        @(negedge clk);
        halt = 1'b0;
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 8'h10 || imem_req !== 1'b0) begin
            errors++; $display("FAIL halt_enter: halted=%b valid=%b addr=%h req=%b exp 1/0/10/0", halted, instr_valid, imem_addr, imem_req);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || halted !== 1'b1) begin
                errors++; $display("FAIL halt_stay_%0d: req=%b halted=%b exp 0/1", i, imem_req, halted);
            end
        end
        pc_overwrite = 1'b1; overwrite_data = 8'h20;
        @(negedge clk);
        pc_overwrite = 1'b0;
        checks++; if (imem_addr !== 8'h20 || imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL halt_ovw: addr=%h req=%b halted=%b valid=%b exp 20/0/1/0", imem_addr, imem_req, halted, instr_valid);
        end
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_no_restart: req=%b exp 0", imem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL halt_reset: halted=%b addr=%h exp 0/00", halted, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL halt_rewake: req=%b addr=%h exp 1/00", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || imem_addr !== 8'h01) begin
            errors++; $display("FAIL halt_refetch: valid=%b ipc=%h addr=%h exp 1/00/01", instr_valid, instr_pc, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre: req=%b valid=%b exp 1/1", imem_req, instr_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 8'h00 || imem_addr !== 8'h00 || halted !== 1'b0) begin
            errors++; $display("FAIL areset_now: req=%b valid=%b instr=%h ipc=%h addr=%h halted=%b exp 0/0/0000/00/00/0",
                               imem_req, instr_valid, instr, instr_pc, imem_addr, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL areset_wake: valid=%b req=%b addr=%h exp 0/1/00", instr_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== word_at(8'h00)) begin
            errors++; $display("FAIL areset_first: valid=%b ipc=%h instr=%h exp 1/00/%h", instr_valid, instr_pc, instr, word_at(8'h00));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_overwrite   = 1'b0;
        overwrite_data = 8'h00;
        stall          = 1'b0;
        halt           = 1'b0;
        imem_ack       = 1'b1;
        test_reset();
        test_sequential();
        test_wrap();
        test_stall();
        test_overwrite();
        test_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pc_fetch
`default_nettype wire
